// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage.
// Size codes match the data memory's section select encoding.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } lsu_state_t;

   localparam logic [1:0] SEC_BYTE = 2'b00;
   localparam logic [1:0] SEC_HALF = 2'b01;
   localparam logic [1:0] SEC_WORD = 2'b10;
   localparam logic [1:0] SEC_NONE = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef struct packed {
      logic        store;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } lsu_req_t;

   function automatic logic [2:0] sec_size(input logic [1:0] sec);
      logic [2:0] sz;
      unique case (sec)
         SEC_BYTE: sz = 3'd1;
         SEC_HALF: sz = 3'd2;
         default:  sz = 3'd4;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data sign/zero extension from the low lanes of raw memory data.
// Combinational; shared with writeback forwarding.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   always_comb begin
      data = raw;
      unique case (funct3)
         F3_LB:   data = {{24{raw[7]}}, raw[7:0]};
         F3_LH:   data = {{16{raw[15]}}, raw[15:0]};
         F3_LBU:  data = {24'h0, raw[7:0]};
         F3_LHU:  data = {16'h0, raw[15:0]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage feeding the data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_N = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rd_i,
   output logic        mem_rw_o,
   output logic [1:0]  mem_sec_o,
   output logic [31:0] mem_wdata_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_data_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        stall_o,
   output logic        err_o
);

   lsu_state_t  state_q, state_d;
   lsu_req_t    req_q;
   logic        err_q;
   logic [31:0] wb_data_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] ext_data;

   logic        accept;
   logic        legal;
   logic        f3_ok;
   logic        range_ok;
   logic        align_ok;
   logic [32:0] last_byte;

   assign accept = (state_q == S_IDLE) & req_valid_i
                 & (is_load_i | is_store_i);

   always_comb begin
      f3_ok = 1'b0;
      if (is_store_i)
         f3_ok = (funct3_i == F3_SB) | (funct3_i == F3_SH)
               | (funct3_i == F3_SW);
      else
         f3_ok = (funct3_i == F3_LB) | (funct3_i == F3_LH)
               | (funct3_i == F3_LW) | (funct3_i == F3_LBU)
               | (funct3_i == F3_LHU);
   end

   // 33-bit sum so a wrap near 2^32 cannot look in range
   assign last_byte = {1'b0, addr_i}
                    + {30'd0, sec_size(funct3_i[1:0])} - 33'd1;
   assign range_ok  = last_byte <= 33'(MEM_N);

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      align_ok = 1'b1;
      if (funct3_i[1:0] == SEC_HALF)
         align_ok = ~addr_i[0];
      else if (funct3_i[1:0] == SEC_WORD)
         align_ok = (addr_i[1:0] == 2'b00);
   end
`else
   assign align_ok = 1'b1;
`endif

   assign legal = ~(is_load_i & is_store_i) & f3_ok
                & range_ok & align_ok;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept & legal) state_d = S_ISSUE;
         S_ISSUE: state_d = req_q.store ? S_IDLE : S_WAIT;
         S_WAIT:  state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         req_q     <= '0;
         err_q     <= 1'b0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= accept & ~legal;
         if (accept & legal) begin
            req_q.store  <= is_store_i;
            req_q.funct3 <= funct3_i;
            req_q.addr   <= addr_i;
            req_q.wdata  <= wdata_i;
            req_q.rd     <= rd_i;
         end
         if (state_q == S_WAIT) begin
            wb_data_q <= ext_data;
            wb_rd_q   <= req_q.rd;
         end
      end
   end

   lsu_load_ext u_ext (
      .funct3 (req_q.funct3),
      .raw    (mem_data_i),
      .data   (ext_data)
   );

   assign req_ready_o = (state_q == S_IDLE);
   assign stall_o     = (state_q != S_IDLE);
   assign wb_valid_o  = (state_q == S_RESP);
   assign wb_data_o   = wb_data_q;
   assign wb_rd_o     = wb_rd_q;
   assign err_o       = err_q;

   assign mem_rw_o    = (state_q == S_ISSUE) & req_q.store;
   assign mem_sec_o   = (state_q == S_ISSUE) ? req_q.funct3[1:0]
                                             : SEC_NONE;
   assign mem_addr_o  = req_q.addr;
   assign mem_wdata_o = mem_rw_o ? req_q.wdata : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model
// and a queue of expected writebacks.
module tb_lsu_ctrl;

   localparam int MEM_N = 20;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        is_load_i;
   logic        is_store_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [4:0]  rd_i;
   logic        mem_rw_o;
   logic [1:0]  mem_sec_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_i = 32'h0;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        stall_o;
   logic        err_o;

   always #5 clk = ~clk;

   lsu_ctrl #(.MEM_N(MEM_N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .is_load_i   (is_load_i),
      .is_store_i  (is_store_i),
      .funct3_i    (funct3_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rd_i        (rd_i),
      .mem_rw_o    (mem_rw_o),
      .mem_sec_o   (mem_sec_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_i  (mem_data_i),
      .wb_valid_o  (wb_valid_o),
      .wb_rd_o     (wb_rd_o),
      .wb_data_o   (wb_data_o),
      .stall_o     (stall_o),
      .err_o       (err_o)
   );

   // data memory model: registered read, little-endian, low-lane aligned
   logic [7:0] mem [0:MEM_N] = '{default: 8'h00};

   always @(posedge clk) begin
      int n;
      logic [31:0] rd;
      n = (mem_sec_o == 2'b00) ? 1 : (mem_sec_o == 2'b01) ? 2 : 4;
      if (mem_rw_o) begin
         for (int i = 0; i < n; i++)
            if (int'(mem_addr_o) + i <= MEM_N)
               mem[int'(mem_addr_o) + i] <= mem_wdata_o[8*i +: 8];
      end else if (mem_sec_o != 2'b11) begin
         rd = 32'h0;
         for (int i = 0; i < n; i++)
            if (int'(mem_addr_o) + i <= MEM_N)
               rd[8*i +: 8] = mem[int'(mem_addr_o) + i];
         mem_data_i <= rd;
      end
   end

   int wb_cnt = 0;
   int rw_cnt = 0;

   always @(negedge clk) begin
      if (wb_valid_o) wb_cnt++;
      if (mem_rw_o) rw_cnt++;
   end

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_req(input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic exp_err, input logic [31:0] exp_d,
                         input string tag);
      int wb0, rw0, n;
      exp_t e;
      tick();
      check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      wb0 = wb_cnt;
      rw0 = rw_cnt;
      req_valid_i = 1'b1;
      is_load_i   = ld;
      is_store_i  = st;
      funct3_i    = f3;
      addr_i      = a;
      wdata_i     = wd;
      rd_i        = rd;
      tick();
      req_valid_i = 1'b0;
      is_load_i   = 1'b0;
      is_store_i  = 1'b0;
      if (exp_err) begin
         check({tag, "_err"}, 32'(err_o), 32'd1);
         check({tag, "_err_rdy"}, 32'(req_ready_o), 32'd1);
         check({tag, "_err_stall"}, 32'(stall_o), 32'd0);
         tick();
         check({tag, "_err_pulse"}, 32'(err_o), 32'd0);
         tick();
         check({tag, "_err_nowb"}, 32'(wb_cnt - wb0), 32'd0);
         check({tag, "_err_norw"}, 32'(rw_cnt - rw0), 32'd0);
      end else if (st) begin
         check({tag, "_rw"}, 32'(mem_rw_o), 32'd1);
         check({tag, "_sec"}, 32'(mem_sec_o), 32'(f3[1:0]));
         check({tag, "_addr"}, mem_addr_o, a);
         check({tag, "_wdata"}, mem_wdata_o, wd);
         check({tag, "_stall"}, 32'(stall_o), 32'd1);
         tick();
         check({tag, "_rw_off"}, 32'(mem_rw_o), 32'd0);
         check({tag, "_rdy2"}, 32'(req_ready_o), 32'd1);
         check({tag, "_rwcnt"}, 32'(rw_cnt - rw0), 32'd1);
      end else begin
         e.rd = rd;
         e.data = exp_d;
         sbq.push_back(e);
         check({tag, "_err0"}, 32'(err_o), 32'd0);
         check({tag, "_sec"}, 32'(mem_sec_o), 32'(f3[1:0]));
         check({tag, "_addr"}, mem_addr_o, a);
         n = 0;
         while (!wb_valid_o && n < 6) begin
            check({tag, "_norw"}, 32'(mem_rw_o), 32'd0);
            tick();
            n++;
         end
         check({tag, "_lat"}, 32'(n), 32'd2);
         if (wb_valid_o && sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, "_wbrd"}, 32'(wb_rd_o), 32'(e.rd));
            check({tag, "_wbdata"}, wb_data_o, e.data);
         end
         tick();
         check({tag, "_wbpulse"}, 32'(wb_valid_o), 32'd0);
         check({tag, "_hold"}, wb_data_o, exp_d);
         check({tag, "_rdy2"}, 32'(req_ready_o), 32'd1);
      end
   endtask

   initial begin
      int wb0;
      rst = 1'b1;
      req_valid_i = 1'b0;
      is_load_i = 1'b0;
      is_store_i = 1'b0;
      funct3_i = 3'b000;
      addr_i = 32'h0;
      wdata_i = 32'h0;
      rd_i = 5'd0;
      tick();
      tick();
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_wbv", 32'(wb_valid_o), 32'd0);
      check("rst_sec", 32'(mem_sec_o), 32'd3);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_wbdata", wb_data_o, 32'h0);
      rst = 1'b0;

      do_req(0, 1, 3'b010, 32'd4, 32'hDEADBEEF, 5'd0, 0, 0, "sw4");
      do_req(1, 0, 3'b010, 32'd4, 0, 5'd5, 0, 32'hDEADBEEF, "lw4");
      do_req(1, 0, 3'b000, 32'd7, 0, 5'd6, 0, 32'hFFFFFFDE, "lb7");
      do_req(1, 0, 3'b100, 32'd7, 0, 5'd7, 0, 32'h000000DE, "lbu7");
      do_req(1, 0, 3'b001, 32'd4, 0, 5'd8, 0, 32'hFFFFBEEF, "lh4");
      do_req(1, 0, 3'b101, 32'd4, 0, 5'd9, 0, 32'h0000BEEF, "lhu4");
      do_req(1, 0, 3'b010, 32'd18, 0, 5'd1, 1, 0, "lw18");
      do_req(0, 1, 3'b000, 32'd19, 32'h34, 5'd0, 0, 0, "sb19");
      do_req(0, 1, 3'b000, 32'd20, 32'h92, 5'd0, 0, 0, "sb20");
      do_req(1, 0, 3'b001, 32'd19, 0, 5'd2, TRAP, 32'hFFFF9234, "lh19");
      do_req(1, 0, 3'b101, 32'd19, 0, 5'd3, TRAP, 32'h00009234, "lhu19");
      do_req(1, 0, 3'b000, 32'd20, 0, 5'd4, 0, 32'hFFFFFF92, "lb20");
      do_req(1, 0, 3'b000, 32'd21, 0, 5'd4, 1, 0, "lb21");
      do_req(1, 0, 3'b010, 32'd16, 0, 5'd10, 0, 32'h34000000, "lw16");
      do_req(1, 0, 3'b100, 32'd20, 0, 5'd0, 0, 32'h00000092, "lbu_rd0");
      do_req(1, 0, 3'b011, 32'd0, 0, 5'd1, 1, 0, "ld_f3_011");
      do_req(1, 1, 3'b010, 32'd0, 0, 5'd1, 1, 0, "ld_and_st");
      do_req(0, 1, 3'b100, 32'd0, 0, 5'd0, 1, 0, "st_f3_100");
      do_req(1, 0, 3'b001, 32'd5, 0, 5'd11, TRAP, 32'hFFFFADBE, "lh5");

      // valid without load or store is ignored
      tick();
      req_valid_i = 1'b1;
      addr_i = 32'd99;
      tick();
      req_valid_i = 1'b0;
      check("nop_err", 32'(err_o), 32'd0);
      check("nop_stall", 32'(stall_o), 32'd0);

      // reset while a load waits on memory
      wb0 = wb_cnt;
      req_valid_i = 1'b1;
      is_load_i = 1'b1;
      funct3_i = 3'b010;
      addr_i = 32'd4;
      rd_i = 5'd12;
      tick();
      req_valid_i = 1'b0;
      is_load_i = 1'b0;
      check("rstmid_issue", 32'(stall_o), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      check("rstmid_wbv", 32'(wb_valid_o), 32'd0);
      check("rstmid_ready", 32'(req_ready_o), 32'd1);
      check("rstmid_stall", 32'(stall_o), 32'd0);
      check("rstmid_err", 32'(err_o), 32'd0);
      check("rstmid_rw", 32'(mem_rw_o), 32'd0);
      check("rstmid_sec", 32'(mem_sec_o), 32'd3);
      check("rstmid_addr", mem_addr_o, 32'h0);
      check("rstmid_wdata", mem_wdata_o, 32'h0);
      check("rstmid_wbrd", 32'(wb_rd_o), 32'd0);
      check("rstmid_wbdata", wb_data_o, 32'h0);
      rst = 1'b0;
      repeat (4) tick();
      check("rstmid_nowb", 32'(wb_cnt - wb0), 32'd0);
      check("sb_empty", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the data-memory stage `mem`.
- Takes execute-stage results (address, store data, funct3, rd) through a valid/ready handshake.
- Drives `mem` control and data inputs, waits one cycle for `mem`'s registered read data, then sign- or zero-extends the load and hands it to writeback.
- Holds the pipeline (`stall_o`) while an access is in flight.

Parameters:
- MEM_N, 20, highest valid byte address of `mem`; must equal `mem` parameter n.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  execute stage presents a memory request
- req_ready_o  out  1  lsu can accept a request
- is_load_i  in  1  request is a load
- is_store_i  in  1  request is a store
- funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- addr_i  in  32  effective byte address
- wdata_i  in  32  store data (rs2)
- rd_i  in  5  load destination register
- mem_rw_o  out  1  to `mem` memRW: 1 write, 0 read
- mem_sec_o  out  2  to `mem` dataSec_i: 00 byte, 01 half, 10 word, 11 none
- mem_wdata_o  out  32  to `mem` dataW_i
- mem_addr_o  out  32  to `mem` addr_i
- mem_data_i  in  32  from `mem` data_o (registered, valid the cycle after the address is presented)
- wb_valid_o  out  1  one-cycle pulse: load result valid
- wb_rd_o  out  5  load destination
- wb_data_o  out  32  extended load data
- stall_o  out  1  pipeline hold
- err_o  out  1  one-cycle pulse: illegal or out-of-range request

Behaviour:
- Reset is synchronous and active-high on clk.
  - State = IDLE.
  - req_ready_o = 1, wb_valid_o = 0, wb_rd_o = 0, wb_data_o = 0, err_o = 0, stall_o = 0.
  - mem_rw_o = 0, mem_sec_o = 11, mem_addr_o = 0, mem_wdata_o = 0.
- Reset mid-operation discards any pending load; no wb_valid_o pulse follows.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - When req_valid_i & (is_load_i | is_store_i), the request is registered and validated.
  - A legal request goes to ISSUE. An illegal one pulses err_o the next cycle and stays in IDLE.
  - req_valid_i with neither is_load_i nor is_store_i is ignored.
- Illegal request, which performs no memory access:
  - is_load_i & is_store_i both high.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 other than {000, 001, 010}.
  - addr + size - 1 > MEM_N, where size = 1/2/4 from funct3[1:0].
- ISSUE (one cycle):
  - Outputs are driven from registered fields only.
  - mem_addr_o = addr; mem_sec_o = funct3[1:0]; mem_rw_o = store; mem_wdata_o = wdata for stores, 0 for loads.
  - Stores go to IDLE, with the write committed by `mem` at this edge.
  - Loads go to WAIT.
- WAIT:
  - mem_rw_o = 0, mem_sec_o = 11, mem_addr_o unchanged.
  - mem_data_i is sampled at the end of the cycle.
  - Go to RESP.
- RESP:
  - wb_valid_o = 1 for exactly one cycle; wb_data_o and wb_rd_o are held until the next load.
  - Go to IDLE.
- Load extension:
  - LB: sign-extend bit 7. LH: sign-extend bit 15. LW: pass through.
  - LBU/LHU: zero-extend [7:0] / [15:0].
  - Always use the low lanes of mem_data_i, since `mem` returns byte-aligned data.
- stall_o = (state != IDLE). req_ready_o = (state == IDLE). A new request is accepted in IDLE even in the cycle following RESP.
- Latency from acceptance edge:
  - Store: write at edge +2 (ISSUE edge); lsu ready again at +2.
  - Load: wb_valid_o high in cycle +3.
- Load with rd = 0: the access is performed and wb_valid_o pulses with wb_rd_o = 0; writeback ignores it.
- Outside ISSUE, mem_rw_o is always 0, so there is no spurious write.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0] != 0, or word with addr[1:0] != 0, is illegal (err_o pulse, no access).
- Undefined: misaligned accesses pass to `mem` unchanged, since `mem` is byte-addressed and handles them natively.

Decomposition:
- lsu_pkg holds:
  - State enum lsu_state_t.
  - Size codes SEC_BYTE=2'b00, SEC_HALF=2'b01, SEC_WORD=2'b10, SEC_NONE=2'b11.
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-module lsu_load_ext: combinational funct3 + 32-bit raw data -> 32-bit extended data; reused by writeback forwarding.

Test Plan:
- SW addr=4 wdata=0xDEADBEEF, then LW addr=4 -> mem_rw_o=1 only in ISSUE cycle; wb_valid_o 3 cycles after load accept, wb_data_o=0xDEADBEEF.
- After the above, LB addr=7 -> wb_data_o=0xFFFFFFDE; LBU addr=7 -> 0x000000DE; LH addr=4 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
- LW addr=18 with MEM_N=20 -> err_o pulse, no mem_rw_o, no wb_valid_o; LH addr=19 -> legal.
- Load funct3=011, or is_load_i=is_store_i=1 -> err_o pulse, state stays IDLE, req_ready_o stays 1.
- LW accepted, rst asserted in WAIT -> no wb_valid_o pulse; all outputs at reset values next cycle.
- LH addr=5: with LSU_MISALIGN_TRAP_EN -> err_o; without -> normal access returning bytes 5..6.
